// File: rtl/bram_load_store_unit.sv
// bram_load_store_unit
//    Front end that turns byte-addressed load/store requests into strobes for
//    one port of a dual-port block RAM. The unit aligns, masks and extends
//    byte, halfword and word accesses. Only one transaction is in flight.
//
// Ports
//    clk, reset           clock (rising edge), asynchronous active-high reset
//    req_valid/req_ready  request handshake
//    req_write            1 = store, 0 = load
//    req_addr             byte address
//    req_size             00 byte, 01 half, 10 word, 11 illegal
//    req_unsigned         loads: 1 = zero-extend, 0 = sign-extend
//    req_wdata            right-justified store data
//    resp_valid/ready     response handshake
//    resp_rdata           load result (0 for stores and errors)
//    resp_error           request was rejected without touching memory
//    mem_*                BRAM port: address, rd_en, wr_data, byte wr_en, rd_data

module bram_load_store_unit #(
   parameter  int CAPACITY_BYTES = 128,
   localparam int ADDR_BITS      = $clog2(CAPACITY_BYTES)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [31:0]          req_addr,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_rdata,
   output logic                 resp_error,
   output logic [ADDR_BITS-1:0] mem_address,
   output logic                 mem_rd_en,
   output logic [31:0]          mem_wr_data,
   output logic [3:0]           mem_wr_en,
   input  logic [31:0]          mem_rd_data
);

   typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

   state_t      state_q, state_d;
   logic [31:0] respRdata_q, respRdata_d;
   logic        respError_q, respError_d;
   logic [1:0]  loadOff_q, loadOff_d;
   logic [1:0]  loadSize_q, loadSize_d;
   logic        loadUnsigned_q, loadUnsigned_d;

   logic        reqErr;
   logic        accept;
   logic        memActive;
   logic [31:0] laneShifted;
   logic [31:0] loadResult;

   // The reset term keeps the request side quiet while reset is asserted,
   // even though the state register already reads IDLE.
   assign req_ready  = (state_q == IDLE) && !reset;
   assign accept     = req_valid && req_ready;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = respRdata_q;
   assign resp_error = respError_q;

   // A request is rejected if its size is illegal, it is misaligned for its
   // size, or it falls outside the attached memory.
   always_comb begin
      reqErr = 1'b0;
      unique case (req_size)
         2'b00:   reqErr = 1'b0;
         2'b01:   reqErr = req_addr[0];
         2'b10:   reqErr = (req_addr[1:0] != 2'b00);
         default: reqErr = 1'b1;
      endcase
      if (req_addr >= 32'(CAPACITY_BYTES))
         reqErr = 1'b1;
   end

   assign memActive = accept && !reqErr;

   // BRAM strobes are driven straight from the request so that a store
   // commits, and a load's read is issued, on the accept edge itself.
   // Store data is replicated across lanes; the byte enables pick the lanes.
   always_comb begin
      mem_address = '0;
      mem_rd_en   = 1'b0;
      mem_wr_en   = 4'b0000;
      mem_wr_data = 32'h0;
      if (memActive) begin
         mem_address = req_addr[ADDR_BITS-1:0];
         if (req_write) begin
            unique case (req_size)
               2'b00: begin
                  mem_wr_en   = 4'b0001 << req_addr[1:0];
                  mem_wr_data = {4{req_wdata[7:0]}};
               end
               2'b01: begin
                  mem_wr_en   = 4'b0011 << req_addr[1:0];
                  mem_wr_data = {2{req_wdata[15:0]}};
               end
               default: begin
                  mem_wr_en   = 4'b1111;
                  mem_wr_data = req_wdata;
               end
            endcase
         end else begin
            mem_rd_en = 1'b1;
         end
      end
   end

   // Move the addressed lane down to bit 0, then extend it to 32 bits
   // using the size and signedness captured when the load was accepted.
   assign laneShifted = mem_rd_data >> {loadOff_q, 3'b000};

   always_comb begin
      loadResult = mem_rd_data;
      unique case (loadSize_q)
         2'b00:   loadResult = loadUnsigned_q ? {24'h0, laneShifted[7:0]}
                                              : {{24{laneShifted[7]}}, laneShifted[7:0]};
         2'b01:   loadResult = loadUnsigned_q ? {16'h0, laneShifted[15:0]}
                                              : {{16{laneShifted[15]}}, laneShifted[15:0]};
         default: loadResult = mem_rd_data;
      endcase
   end

   // Next-state logic. Stores and errors answer one cycle after accept;
   // loads spend one extra cycle in LOAD_WAIT collecting BRAM read data.
   // The response registers are only updated on the way into RESP, so they
   // stay stable for as long as the consumer applies backpressure.
   always_comb begin
      state_d        = state_q;
      respRdata_d    = respRdata_q;
      respError_d    = respError_q;
      loadOff_d      = loadOff_q;
      loadSize_d     = loadSize_q;
      loadUnsigned_d = loadUnsigned_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (reqErr) begin
                  state_d     = RESP;
                  respError_d = 1'b1;
                  respRdata_d = 32'h0;
               end else if (req_write) begin
                  state_d     = RESP;
                  respError_d = 1'b0;
                  respRdata_d = 32'h0;
               end else begin
                  state_d        = LOAD_WAIT;
                  loadOff_d      = req_addr[1:0];
                  loadSize_d     = req_size;
                  loadUnsigned_d = req_unsigned;
               end
            end
         end
         LOAD_WAIT: begin
            state_d     = RESP;
            respError_d = 1'b0;
            respRdata_d = loadResult;
         end
         RESP: begin
            if (resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and response registers; reset discards any pending response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         respRdata_q    <= 32'h0;
         respError_q    <= 1'b0;
         loadOff_q      <= 2'b00;
         loadSize_q     <= 2'b00;
         loadUnsigned_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         respRdata_q    <= respRdata_d;
         respError_q    <= respError_d;
         loadOff_q      <= loadOff_d;
         loadSize_q     <= loadSize_d;
         loadUnsigned_q <= loadUnsigned_d;
      end
   end

endmodule

// File: tb/tb_bram_load_store_unit.sv
// tb_bram_load_store_unit
//    Self-checking bench for bram_load_store_unit. A behavioural 1-cycle
//    latency BRAM is attached to the memory port. Expected responses are
//    queued when a request is driven and compared when the DUT responds.

module tb_bram_load_store_unit;

   localparam int CAP = 128;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [6:0]  mem_address;
   logic        mem_rd_en;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_wr_en;
   logic [31:0] mem_rd_data;

   logic [7:0]  ram [CAP];
   logic [7:0]  refMem [CAP];
   resp_t       sbQ [$];
   int          checkCount = 0;
   int          errorCount = 0;

   bram_load_store_unit #(.CAPACITY_BYTES(CAP)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_error   (resp_error),
      .mem_address  (mem_address),
      .mem_rd_en    (mem_rd_en),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_en    (mem_wr_en),
      .mem_rd_data  (mem_rd_data)
   );

   always #5 clk = ~clk;

   // Behavioural BRAM port: byte-enabled writes, registered reads.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (mem_wr_en[i])
            ram[{mem_address[6:2], 2'(i)}] <= mem_wr_data[8*i +: 8];
      if (mem_rd_en)
         mem_rd_data <= {ram[{mem_address[6:2], 2'd3}], ram[{mem_address[6:2], 2'd2}],
                         ram[{mem_address[6:2], 2'd1}], ram[{mem_address[6:2], 2'd0}]};
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference load: assemble little-endian bytes, then extend.
   function automatic logic [31:0] refLoad(input int addr, input int size, input bit uns);
      logic [31:0] v;
      int          nBytes;
      v      = 32'h0;
      nBytes = 1 << size;
      for (int i = 0; i < nBytes; i++)
         v = v | (32'(refMem[addr + i]) << (8 * i));
      if (!uns && nBytes < 4 && v[8*nBytes-1])
         v = v | (32'hFFFF_FFFF << (8 * nBytes));
      return v;
   endfunction

   // Scoreboard consumer: compares every completed response.
   always @(negedge clk) begin
      resp_t e;
      if (!reset && resp_valid && resp_ready) begin
         checkOutput("sb_pending", 32'(sbQ.size() > 0), 32'd1);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("resp_rdata", resp_rdata, e.rdata);
            checkOutput("resp_error", 32'(resp_error), 32'(e.err));
         end
      end
   end

   // One full transaction: drive, check accept-cycle strobes, queue the
   // expected response, then check latency and that the port stays quiet.
   task automatic applyStimulus(input string tag, input bit wr, input logic [31:0] addr,
                                input logic [1:0] size, input bit uns,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input bit expErr, input logic [3:0] expWrEn,
                                input logic [31:0] expWrData);
      resp_t e;
      int    lat;
      bit    strobeSeen;
      @(posedge clk); #1;
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      @(negedge clk);
      checkOutput({tag, "_ready"}, 32'(req_ready), 32'd1);
      checkOutput({tag, "_wr_en"}, 32'(mem_wr_en), 32'(expWrEn));
      checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 32'(!wr && !expErr));
      checkOutput({tag, "_addr"}, 32'(mem_address), expErr ? 32'h0 : 32'(addr[6:0]));
      if (wr && !expErr)
         checkOutput({tag, "_wr_data"}, mem_wr_data, expWrData);
      e.rdata = expRdata;
      e.err   = expErr;
      sbQ.push_back(e);
      @(posedge clk); #1;
      req_valid    = 1'b0;
      req_write    = 1'($urandom);
      req_addr     = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = $urandom;
      lat        = 0;
      strobeSeen = 1'b0;
      for (int n = 1; n <= 4 && lat == 0; n++) begin
         @(negedge clk);
         if (mem_rd_en || mem_wr_en != 4'b0000) strobeSeen = 1'b1;
         if (resp_valid) lat = n;
      end
      checkOutput({tag, "_latency"}, 32'(lat), (!wr && !expErr) ? 32'd2 : 32'd1);
      checkOutput({tag, "_quiet"}, 32'(strobeSeen), 32'd0);
      @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit flag;
      int a;
      int sz;
      bit un;
      logic [31:0] wd;
      for (int i = 0; i < CAP; i++) begin
         ram[i]    = 8'h00;
         refMem[i] = 8'h00;
      end
      mem_rd_data  = 32'h0;
      reset        = 1'b1;
      resp_ready   = 1'b1;
      req_valid    = 1'b1;
      req_write    = 1'b0;
      req_addr     = 32'h10;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_wdata    = 32'h0;

      // Reset state, with a legal request presented.
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_resp_error", 32'(resp_error), 32'd0);
      checkOutput("rst_rd_en", 32'(mem_rd_en), 32'd0);
      checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
      @(posedge clk); #1;
      reset     = 1'b0;
      req_valid = 1'b0;

      // Directed stores and loads of each size.
      applyStimulus("st_w10", 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF);
      applyStimulus("ld_w10", 0, 32'h10, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0, 4'b0000, 32'h0);
      applyStimulus("st_b13", 1, 32'h13, 2'b00, 0, 32'h12345680, 32'h0, 0, 4'b1000, 32'h80808080);
      applyStimulus("ld_b13s", 0, 32'h13, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0, 4'b0000, 32'h0);
      applyStimulus("ld_b13u", 0, 32'h13, 2'b00, 1, 32'h0, 32'h00000080, 0, 4'b0000, 32'h0);
      applyStimulus("st_b11", 1, 32'h11, 2'b00, 0, 32'hFFFFFF5A, 32'h0, 0, 4'b0010, 32'h5A5A5A5A);
      applyStimulus("ld_b11s", 0, 32'h11, 2'b00, 0, 32'h0, 32'h0000005A, 0, 4'b0000, 32'h0);
      applyStimulus("ld_w10b", 0, 32'h10, 2'b10, 0, 32'h0, 32'h80AD5AEF, 0, 4'b0000, 32'h0);
      applyStimulus("st_h22", 1, 32'h22, 2'b01, 0, 32'hABCD8001, 32'h0, 0, 4'b1100, 32'h80018001);
      applyStimulus("ld_h22s", 0, 32'h22, 2'b01, 0, 32'h0, 32'hFFFF8001, 0, 4'b0000, 32'h0);
      applyStimulus("ld_h22u", 0, 32'h22, 2'b01, 1, 32'h0, 32'h00008001, 0, 4'b0000, 32'h0);
      applyStimulus("ld_h20s", 0, 32'h20, 2'b01, 0, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0);

      // Rejected requests: none may reach the memory.
      applyStimulus("err_w06", 1, 32'h06, 2'b10, 0, 32'h11111111, 32'h0, 1, 4'b0000, 32'h0);
      applyStimulus("err_h01", 0, 32'h01, 2'b01, 0, 32'h0, 32'h0, 1, 4'b0000, 32'h0);
      applyStimulus("err_sz3", 1, 32'h10, 2'b11, 0, 32'h22222222, 32'h0, 1, 4'b0000, 32'h0);
      applyStimulus("err_a80", 1, 32'h80, 2'b10, 0, 32'h33333333, 32'h0, 1, 4'b0000, 32'h0);
      applyStimulus("ld_w10c", 0, 32'h10, 2'b10, 0, 32'h0, 32'h80AD5AEF, 0, 4'b0000, 32'h0);
      applyStimulus("ld_w00", 0, 32'h00, 2'b10, 0, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0);
      applyStimulus("ld_w04", 0, 32'h04, 2'b10, 0, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0);

      // Backpressure: a legal store stays presented while the response waits.
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10;
      req_unsigned = 1'b0; resp_ready = 1'b0;
      sbQ.push_back('{rdata: 32'h80AD5AEF, err: 1'b0});
      @(posedge clk); #1;
      req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("bp_resp_rdata", resp_rdata, 32'h80AD5AEF);
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_strobes", 32'(mem_rd_en || mem_wr_en != 4'b0000), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_release_ready", 32'(req_ready), 32'd1);

      // Reset while a load is waiting for BRAM data.
      @(posedge clk); #1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = 2'b10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset     = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
      checkOutput("mid_rst_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      flag  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (resp_valid) flag = 1'b1;
      end
      checkOutput("mid_rst_no_resp", 32'(flag), 32'd0);
      applyStimulus("post_rst_ld", 0, 32'h10, 2'b10, 0, 32'h0, 32'h80AD5AEF, 0, 4'b0000, 32'h0);
      applyStimulus("ld_w20", 0, 32'h20, 2'b10, 0, 32'h0, 32'h80010000, 0, 4'b0000, 32'h0);

      // Random word stores and mixed-size loads in the upper half of memory.
      for (int k = 0; k < 8; k++) begin
         a  = 32'h40 + 4 * int'($urandom_range(0, 15));
         wd = $urandom;
         for (int i = 0; i < 4; i++) refMem[a + i] = wd[8*i +: 8];
         applyStimulus("rnd_st", 1, 32'(a), 2'b10, 0, wd, 32'h0, 0, 4'b1111, wd);
         sz = int'($urandom_range(0, 2));
         un = 1'($urandom);
         a  = a + ((sz == 0) ? int'($urandom_range(0, 3)) : (sz == 1) ? 2 * int'($urandom_range(0, 1)) : 0);
         applyStimulus("rnd_ld", 0, 32'(a), 2'(sz), un, 32'h0, refLoad(a, sz, un), 0, 4'b0000, 32'h0);
      end

      @(negedge clk);
      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/bram_load_store_unit.md
Name: bram_load_store_unit

Overview:
- Request/response front end that turns byte-addressed load/store transactions into BRAM port strobes.
- Drives one port of the dual-port block memory (address, rd_en, wr_data, byte wr_en) and consumes its 1-cycle-latency read data.
- Aligns, masks and sign/zero-extends byte, halfword and word loads and stores.
- Sits between a CPU load/store stage or bus master and the BRAM; one transaction in flight at a time.

Parameters:
- CAPACITY_BYTES, 128: memory size; must match the attached BRAM. Power of two, at least 4.
- ADDR_BITS, $clog2(CAPACITY_BYTES): localparam, BRAM address width.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  request rejected, no memory access made.
- mem_address  out  ADDR_BITS  to BRAM port address.
- mem_rd_en  out  1  to BRAM port rd_en.
- mem_wr_data  out  32  to BRAM port wr_data.
- mem_wr_en  out  4  to BRAM port byte write enables.
- mem_rd_data  in  32  from BRAM port rd_data.

Behaviour:
- Clock/reset: single clock clk. reset is asynchronous and active-high.
- While reset is high:
  - state = IDLE.
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - mem_rd_en = 0, mem_wr_en = 0.
- The BRAM port reset is tied to the same reset.

States: IDLE, LOAD_WAIT, RESP.
- IDLE:
  - req_ready = 1 (when not in reset).
  - Accept occurs on a rising edge with req_valid & req_ready.
- Error condition (err), evaluated combinationally in IDLE:
  - req_size = 11, or
  - half with req_addr[0] = 1, or
  - word with req_addr[1:0] != 0, or
  - req_addr >= CAPACITY_BYTES.
- Memory strobes are combinational, and are active only when state = IDLE & req_valid & !err & !reset:
  - mem_address = req_addr[ADDR_BITS-1:0].
  - Load: mem_rd_en = 1, mem_wr_en = 0.
  - Store: mem_rd_en = 0. mem_wr_en is: byte 0001 shifted left by addr[1:0]; half 0011 shifted left by addr[1:0]; word 1111.
  - Store wr_data: byte is wdata[7:0] replicated ×4; half is wdata[15:0] replicated ×2; word is wdata.
  - Otherwise all strobes are 0 and mem_address = 0.
- Transitions on accept:
  - err: go to RESP with resp_error = 1, resp_rdata = 0. BRAM is untouched.
  - Store: the write commits at the accept edge. Go to RESP with resp_error = 0, resp_rdata = 0.
  - Load: latch addr[1:0], size and unsigned. Go to LOAD_WAIT.
- LOAD_WAIT (exactly 1 cycle):
  - mem_rd_data is valid in this cycle.
  - Select the lane by the latched addr[1:0] and size.
  - Extend to 32 bits per req_unsigned.
  - Register into resp_rdata; go to RESP.
- RESP:
  - resp_valid = 1; resp_rdata and resp_error are held stable until the handshake.
  - On resp_valid & resp_ready, go to IDLE.
  - req_ready is 0 throughout RESP; there is no back-to-back overlap.
- Latency, accept edge to resp_valid high:
  - Store or error: 1 cycle.
  - Load: 2 cycles.
- Throughput, with resp_ready held at 1:
  - Store: one per 2 cycles.
  - Load: one per 3 cycles.
- Backpressure: resp_ready low holds RESP indefinitely. No new BRAM access is issued during this time.
- Inputs are don't-care outside IDLE. req_* changes in LOAD_WAIT or RESP have no effect.
- Reset mid-operation (any state): immediate return to IDLE with all outputs at reset values. Any pending response is discarded.

Test Plan:
- Store word 0xDEADBEEF at addr 0x10 -> mem_wr_en = 1111, mem_address = 0x10 in the accept cycle; resp_valid next cycle, resp_error = 0. A following word load at 0x10 returns 0xDEADBEEF 2 cycles after accept.
- Store byte 0x80 at 0x13, then load 0x13:
  - mem_wr_en = 1000, mem_wr_data = 0x80808080.
  - Signed byte load returns 0xFFFFFF80; unsigned byte load returns 0x00000080.
- Store half 0x8001 at 0x22, then load half 0x22:
  - mem_wr_en = 1100.
  - Signed load returns 0xFFFF8001; unsigned load returns 0x00008001.
- Error cases: word at 0x06, half at 0x01, size 11, and addr 0x80 (CAPACITY_BYTES = 128). Each -> mem_wr_en = 0 and mem_rd_en = 0 throughout; resp_error = 1 and resp_rdata = 0 one cycle after accept. Prior memory contents are unchanged.
- Backpressure: load with resp_ready held low for 5 cycles -> resp_valid and resp_rdata stay stable. req_ready = 0 and no strobes for the whole period. Release -> req_ready = 1 on the next cycle.
- Assert reset during LOAD_WAIT -> resp_valid never rises and req_ready = 0 while reset is high. After release, IDLE is entered and a new word load returns the correct data.
